// File: rtl/wb_periph_reg_bridge_pkg.sv
// Shared types and constants for the Wishbone to reg-bus bridge.
package wbr_pkg;

    // Bridge access sequencing.
    typedef enum logic [1:0] {
        WBR_IDLE = 2'd0,
        WBR_REQ  = 2'd1,
        WBR_RESP = 2'd2
    } wbr_state_t;

    // Read data returned on a watchdog-terminated access.
    localparam logic [31:0] WBR_ERR_RDATA = 32'hDEAD_BEEF;

    // Width of the access watchdog counter.
    localparam int unsigned WBR_CNT_W = 8;

endpackage : wbr_pkg

// File: rtl/wb_periph_reg_bridge_if.sv
// Bundle of the Wishbone slave port and the reg-bus master port of the bridge.
interface wb_periph_reg_bridge_if #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 32
) ();

    // Wishbone classic side
    logic              wbs_cyc_i;
    logic              wbs_stb_i;
    logic              wbs_we_i;
    logic [AW-1:0]     wbs_adr_i;
    logic [DW-1:0]     wbs_dat_i;
    logic [DW/8-1:0]   wbs_sel_i;
    logic [DW-1:0]     wbs_dat_o;
    logic              wbs_ack_o;
    logic              wbs_err_o;

    // Reg-bus side towards the peripheral hub
    logic              reg_cs;
    logic              reg_wr;
    logic [AW-1:0]     reg_addr;
    logic [DW-1:0]     reg_wdata;
    logic [DW/8-1:0]   reg_be;
    logic [DW-1:0]     reg_rdata;
    logic              reg_ack;

    // Bridge view: Wishbone slave, reg-bus master.
    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i, wbs_sel_i,
        output wbs_dat_o, wbs_ack_o, wbs_err_o,
        output reg_cs, reg_wr, reg_addr, reg_wdata, reg_be,
        input  reg_rdata, reg_ack
    );

    // Environment view: Wishbone master plus the hub.
    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i, wbs_sel_i,
        input  wbs_dat_o, wbs_ack_o, wbs_err_o,
        input  reg_cs, reg_wr, reg_addr, reg_wdata, reg_be,
        output reg_rdata, reg_ack
    );

endinterface : wb_periph_reg_bridge_if

// File: rtl/wb_periph_reg_bridge.sv
// Wishbone classic slave to single-master reg-bus bridge for the peripheral hub.
// Every request and response is registered; reg_cs is low for at least two
// cycles between accesses. Define WBR_TIMEOUT_EN to bound each access with a
// watchdog that terminates it with a bus error after TIMEOUT_CYC cycles.
module wb_periph_reg_bridge
    import wbr_pkg::*;
#(
    parameter int unsigned AW          = 8,
    parameter int unsigned DW          = 32,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                   app_clk,
    input  logic                   reset_n,
    wb_periph_reg_bridge_if.slave  bus
);

    localparam int unsigned BW = DW / 8;

    // Elaboration guard: the watchdog counter is WBR_CNT_W bits wide.
    if ((TIMEOUT_CYC < 1) || (TIMEOUT_CYC > ((1 << WBR_CNT_W) - 1))) begin : g_bad_timeout
        $error("TIMEOUT_CYC out of range for the watchdog counter");
    end

    wbr_state_t      state_q, state_d;
    logic            cs_q, cs_d;
    logic            wr_q, wr_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [BW-1:0]   be_q, be_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            ack_q, ack_d;
    logic            err_q, err_d;
    logic            expire_c;

`ifdef WBR_TIMEOUT_EN
    logic [WBR_CNT_W-1:0] cnt_q, cnt_d;
    logic [WBR_CNT_W-1:0] cnt_inc_c;

    // Watchdog: this REQ cycle is the last one allowed without a hub ack.
    assign cnt_inc_c = cnt_q + WBR_CNT_W'(1);
    assign expire_c  = (state_q == WBR_REQ) && (cnt_inc_c == WBR_CNT_W'(TIMEOUT_CYC));
`else
    assign expire_c  = 1'b0;
`endif

    // Next-state and next-output decode for the access sequencer.
    always_comb begin
        state_d = state_q;
        cs_d    = cs_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
`ifdef WBR_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            WBR_IDLE: begin
                if (bus.wbs_cyc_i && bus.wbs_stb_i) begin
                    state_d = WBR_REQ;
                    cs_d    = 1'b1;
                    wr_d    = bus.wbs_we_i;
                    addr_d  = bus.wbs_adr_i;
                    wdata_d = bus.wbs_dat_i;
                    be_d    = bus.wbs_sel_i;
`ifdef WBR_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            WBR_REQ: begin
`ifdef WBR_TIMEOUT_EN
                cnt_d = cnt_inc_c;
`endif
                // A hub ack on the expiry cycle still completes normally.
                if (bus.reg_ack) begin
                    state_d = WBR_RESP;
                    cs_d    = 1'b0;
                    rdata_d = bus.reg_rdata;
                    ack_d   = bus.wbs_cyc_i;
                end else if (expire_c) begin
                    state_d = WBR_RESP;
                    cs_d    = 1'b0;
                    rdata_d = DW'(WBR_ERR_RDATA);
                    err_d   = bus.wbs_cyc_i;
                end
            end
            WBR_RESP: begin
                state_d = WBR_IDLE;
            end
            default: begin
                state_d = WBR_IDLE;
                cs_d    = 1'b0;
            end
        endcase
    end

    // State, capture registers and watchdog counter.
    always_ff @(posedge app_clk) begin
        if (!reset_n) begin
            state_q <= WBR_IDLE;
            cs_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
`ifdef WBR_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cs_q    <= cs_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
`ifdef WBR_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign bus.reg_cs    = cs_q;
    assign bus.reg_wr    = wr_q;
    assign bus.reg_addr  = addr_q;
    assign bus.reg_wdata = wdata_q;
    assign bus.reg_be    = be_q;
    assign bus.wbs_dat_o = rdata_q;
    assign bus.wbs_ack_o = ack_q;
`ifdef WBR_TIMEOUT_EN
    assign bus.wbs_err_o = err_q;
`else
    assign bus.wbs_err_o = 1'b0;

    // Without the watchdog no error can be raised; keep the flop tied off.
    logic unused_err;
    assign unused_err = err_q;
`endif

endmodule : wb_periph_reg_bridge
